ysyx_210544_trap_ctrl: RTL and testbench
========================================

Name: ysyx_210544_trap_ctrl

Overview:
- Trap sequencer and CLINT timer placed directly upstream of the CSR file.
- Detects ecall, mret and machine-timer interrupts at instruction commit.
- Updates mepc, mcause and mstatus one CSR access per cycle through the CSR file's single read/write port, then issues a one-cycle PC redirect to the fetch stage.
- Holds the memory-mapped mtime and mtimecmp registers and produces the timer-pending level.

Parameters:
- MTIME_DIV, 1: mtime increments once every MTIME_DIV clk cycles (1..255).
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp.
- ADDR_MTIME, 64'h0200_BFF8: MMIO address of mtime.
- ADDR_MTIMECMP, 64'h0200_4000: MMIO address of mtimecmp.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_commit_valid  in  1  an instruction commits this cycle
- i_commit_pc  in  64  PC of the committing instruction
- i_commit_npc  in  64  PC of the following instruction
- i_ecall  in  1  committing instruction is ecall
- i_mret  in  1  committing instruction is mret
- i_csr_mstatus_mie  in  1  mstatus.MIE level from the CSR file
- i_csr_mie_mtie  in  1  mie.MTIE level from the CSR file
- o_csr_ren  out  1  CSR read enable
- o_csr_wen  out  1  CSR write enable
- o_csr_addr  out  12  CSR address
- o_csr_wdata  out  64  CSR write data
- i_csr_rdata  in  64  CSR read data (combinational, same cycle)
- i_mmio_ren  in  1  MMIO read enable
- i_mmio_wen  in  1  MMIO write enable
- i_mmio_addr  in  64  MMIO address
- i_mmio_wdata  in  64  MMIO write data
- o_mmio_rdata  out  64  MMIO read data (combinational; 0 if address unmatched)
- o_mmio_hit  out  1  i_mmio_addr matches mtime or mtimecmp
- o_mtip  out  1  timer pending: mtime >= mtimecmp (unsigned)
- o_busy  out  1  stall request to the pipeline
- o_redirect  out  1  one-cycle redirect pulse
- o_redirect_pc  out  64  redirect target

Behaviour:
- Reset values: state IDLE, mtime 0, mtimecmp MTIMECMP_RST, prescaler 0; all outputs 0 except o_mtip, which follows the compare (0 at reset with the default parameters).
- mtime: prescaler counts 0..MTIME_DIV-1; mtime+1 when prescaler wraps; 64-bit wrap with no flag.
- MMIO writes: an MMIO write to mtime overrides the increment in the same cycle. An mtimecmp write takes effect on the next cycle; o_mtip updates the same cycle it takes effect.
- Event selection in IDLE, only when i_commit_valid:
  - i_mret wins over i_ecall; i_ecall wins over interrupt.
  - Interrupt is taken when o_mtip & i_csr_mstatus_mie & i_csr_mie_mtie and neither ecall nor mret is committing.
  - Latched values:
    - ecall: epc = i_commit_pc, cause = 64'd11.
    - interrupt: epc = i_commit_npc, cause = 64'h8000_0000_0000_0007.
- o_busy = (state != IDLE) | (event accepted this cycle).
- Inputs are ignored outside IDLE.
- Trap FSM, one state per cycle:
  - ACCEPT(IDLE) -> WR_MEPC (wen 0x341 = epc)
  - -> WR_MCAUSE (wen 0x342 = cause)
  - -> RD_MSTATUS (ren 0x300, latch rdata)
  - -> WR_MSTATUS (wen 0x300: MPIE[7] = old MIE[3], MIE = 0, MPP[12:11] = 2'b11, other bits kept)
  - -> RD_TGT (ren 0x305, target = {rdata[63:2], 2'b00})
  - -> REDIR (o_redirect = 1, o_redirect_pc = target)
  - -> IDLE.
  - o_redirect is asserted 6 cycles after accept.
- mret FSM: ACCEPT -> RD_MSTATUS -> WR_MSTATUS (MIE = old MPIE, MPIE = 1, MPP = 2'b11) -> RD_TGT (ren 0x341, target = rdata) -> REDIR -> IDLE. o_redirect is asserted 4 cycles after accept.
- Port exclusivity: ren and wen are never both high. o_csr_addr = 0 and o_csr_wdata = 0 when neither is high.
- Reset mid-sequence: return to IDLE next cycle with no further CSR writes. Already-written CSRs are not rolled back; the CSR file is reset by the same rst.
- An interrupt that becomes pending during a sequence is evaluated at the first commit after returning to IDLE. MIE is 0 after trap entry, so no nesting occurs.

Optional Feature:
- Macro: YSYX_210544_MTVEC_VECTORED_EN.
- Defined: in RD_TGT, for an interrupt with rdata[1:0] == 2'b01, target = {rdata[63:2], 2'b00} + 4*cause[62:0] (= base + 0x1C for the timer interrupt). Exceptions and mode 2'b00 use the base address.
- Undefined: mtvec[1:0] is ignored and the base address is always used.

Test Plan:
- Reset, then idle 10 cycles with MTIME_DIV = 1: mtime reads back 10 via MMIO; o_mtip = 0; no CSR ren/wen.
- ecall at commit_pc 0x8000_0010, mtvec = 0x8000_0100, mstatus = 0x1808:
  - mepc = 0x8000_0010, mcause = 11, mstatus = 0x1880.
  - o_redirect pulse with pc 0x8000_0100 exactly 6 cycles after accept; o_busy high throughout.
- mret with mstatus = 0x1880, mepc = 0x8000_0014: mstatus = 0x1888; redirect to 0x8000_0014 4 cycles after accept.
- Write mtimecmp = 5; mie.MTIE = 1; mstatus.MIE = 1; commit with npc 0x8000_0020 after o_mtip rises:
  - mcause = 0x8000_0000_0000_0007, mepc = 0x8000_0020.
  - With MIE = 0 instead: no trap.
- Same-cycle i_mret + i_ecall + pending interrupt -> mret sequence only. MMIO write mtime = 100 in the same cycle as an increment -> reads 100 the next cycle.
- Assert rst in WR_MSTATUS -> IDLE next cycle, o_redirect never pulses. Under YSYX_210544_MTVEC_VECTORED_EN with mtvec = 0x8000_0101 and a timer interrupt -> redirect 0x8000_011C.

Source files
------------

// File: rtl/ysyx_210544_trap_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_210544_trap_ctrl
//
// Trap sequencer and CLINT timer sitting in front of the CSR file.
// On commit it detects mret, ecall and the machine-timer interrupt, then walks
// mepc / mcause / mstatus / mtvec (or mepc for mret) through the CSR file's
// single access port one access per cycle, and finishes with a one-cycle
// PC redirect. It also owns the memory-mapped mtime / mtimecmp registers.
//
// Optional build macro: YSYX_210544_MTVEC_VECTORED_EN
//   defined   : vectored mtvec mode (2'b01) offsets interrupt targets by 4*cause
//   undefined : mtvec[1:0] ignored, base address always used
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_commit_*          committing instruction: valid, pc, next pc
//   i_ecall, i_mret     committing instruction class
//   i_csr_mstatus_mie   mstatus.MIE level from the CSR file
//   i_csr_mie_mtie      mie.MTIE level from the CSR file
//   o_csr_ren/wen/addr/wdata, i_csr_rdata   CSR file access port
//   i_mmio_*            MMIO access from the LSU, o_mmio_rdata/o_mmio_hit back
//   o_mtip              timer pending (mtime >= mtimecmp)
//   o_busy              pipeline stall request
//   o_redirect(_pc)     one-cycle fetch redirect
// ---------------------------------------------------------------------------
module ysyx_210544_trap_ctrl #(
    parameter int unsigned MTIME_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter logic [63:0] ADDR_MTIME    = 64'h0200_BFF8,
    parameter logic [63:0] ADDR_MTIMECMP = 64'h0200_4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_commit_valid,
    input  logic [63:0] i_commit_pc,
    input  logic [63:0] i_commit_npc,
    input  logic        i_ecall,
    input  logic        i_mret,
    input  logic        i_csr_mstatus_mie,
    input  logic        i_csr_mie_mtie,
    output logic        o_csr_ren,
    output logic        o_csr_wen,
    output logic [11:0] o_csr_addr,
    output logic [63:0] o_csr_wdata,
    input  logic [63:0] i_csr_rdata,
    input  logic        i_mmio_ren,
    input  logic        i_mmio_wen,
    input  logic [63:0] i_mmio_addr,
    input  logic [63:0] i_mmio_wdata,
    output logic [63:0] o_mmio_rdata,
    output logic        o_mmio_hit,
    output logic        o_mtip,
    output logic        o_busy,
    output logic        o_redirect,
    output logic [63:0] o_redirect_pc
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [63:0] CAUSE_ECALL = 64'd11;
    localparam logic [63:0] CAUSE_MTI   = 64'h8000_0000_0000_0007;

    localparam logic [7:0]  DIV_LAST    = 8'(MTIME_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MEPC,
        S_WR_MCAUSE,
        S_RD_MSTATUS,
        S_WR_MSTATUS,
        S_RD_TGT,
        S_REDIR
    } state_t;

    state_t      state;
    logic        is_mret;
    logic        is_intr;
    logic [7:0]  prescaler;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    // ------------------------------------------------------------------
    // CLINT timer
    // ------------------------------------------------------------------
    logic hit_mtime;
    logic hit_mtimecmp;

    assign hit_mtime    = (i_mmio_addr == ADDR_MTIME);
    assign hit_mtimecmp = (i_mmio_addr == ADDR_MTIMECMP);
    assign o_mmio_hit   = hit_mtime | hit_mtimecmp;
    assign o_mtip       = (mtime >= mtimecmp);

    always_comb begin
        o_mmio_rdata = '0;
        if (i_mmio_ren) begin
            if (hit_mtime)
                o_mmio_rdata = mtime;
            else if (hit_mtimecmp)
                o_mmio_rdata = mtimecmp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            mtime     <= '0;
            mtimecmp  <= MTIMECMP_RST;
        end else begin
            if (prescaler == DIV_LAST)
                prescaler <= '0;
            else
                prescaler <= prescaler + 8'd1;

            // A software write to mtime takes priority over the tick.
            if (i_mmio_wen && hit_mtime)
                mtime <= i_mmio_wdata;
            else if (prescaler == DIV_LAST)
                mtime <= mtime + 64'd1;

            if (i_mmio_wen && hit_mtimecmp)
                mtimecmp <= i_mmio_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Event selection (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic take_mret;
    logic take_ecall;
    logic take_intr;

    assign take_mret  = (state == S_IDLE) && i_commit_valid && i_mret;
    assign take_ecall = (state == S_IDLE) && i_commit_valid && !i_mret && i_ecall;
    assign take_intr  = (state == S_IDLE) && i_commit_valid && !i_mret && !i_ecall &&
                        o_mtip && i_csr_mstatus_mie && i_csr_mie_mtie;

    assign o_busy = (state != S_IDLE) || take_mret || take_ecall || take_intr;

    // ------------------------------------------------------------------
    // Data computed from the same-cycle CSR read
    // ------------------------------------------------------------------
    logic [63:0] mstatus_next;
    logic [63:0] target;

    always_comb begin
        mstatus_next        = i_csr_rdata;
        mstatus_next[12:11] = 2'b11;
        if (is_mret) begin
            mstatus_next[3] = i_csr_rdata[7];
            mstatus_next[7] = 1'b1;
        end else begin
            mstatus_next[7] = i_csr_rdata[3];
            mstatus_next[3] = 1'b0;
        end
    end

    always_comb begin
        if (is_mret) begin
            target = i_csr_rdata;
        end else begin
            target = {i_csr_rdata[63:2], 2'b00};
`ifdef YSYX_210544_MTVEC_VECTORED_EN
            // Vectored mode: interrupts land at base + 4*cause.
            if (is_intr && (i_csr_rdata[1:0] == 2'b01))
                target = {i_csr_rdata[63:2], 2'b00} + {CAUSE_MTI[61:0], 2'b00};
`endif
        end
    end

    // ------------------------------------------------------------------
    // Sequencer. CSR port and redirect outputs are registered: each value
    // is loaded on the transition into the state that owns the access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            is_mret       <= 1'b0;
            is_intr       <= 1'b0;
            o_csr_ren     <= 1'b0;
            o_csr_wen     <= 1'b0;
            o_csr_addr    <= '0;
            o_csr_wdata   <= '0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
        end else begin
            o_csr_ren     <= 1'b0;
            o_csr_wen     <= 1'b0;
            o_csr_addr    <= '0;
            o_csr_wdata   <= '0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;

            case (state)
                S_IDLE: begin
                    if (take_mret) begin
                        is_mret    <= 1'b1;
                        is_intr    <= 1'b0;
                        state      <= S_RD_MSTATUS;
                        o_csr_ren  <= 1'b1;
                        o_csr_addr <= CSR_MSTATUS;
                    end else if (take_ecall || take_intr) begin
                        is_mret     <= 1'b0;
                        is_intr     <= take_intr;
                        state       <= S_WR_MEPC;
                        o_csr_wen   <= 1'b1;
                        o_csr_addr  <= CSR_MEPC;
                        o_csr_wdata <= take_ecall ? i_commit_pc : i_commit_npc;
                    end
                end
                S_WR_MEPC: begin
                    state       <= S_WR_MCAUSE;
                    o_csr_wen   <= 1'b1;
                    o_csr_addr  <= CSR_MCAUSE;
                    o_csr_wdata <= is_intr ? CAUSE_MTI : CAUSE_ECALL;
                end
                S_WR_MCAUSE: begin
                    state      <= S_RD_MSTATUS;
                    o_csr_ren  <= 1'b1;
                    o_csr_addr <= CSR_MSTATUS;
                end
                S_RD_MSTATUS: begin
                    state       <= S_WR_MSTATUS;
                    o_csr_wen   <= 1'b1;
                    o_csr_addr  <= CSR_MSTATUS;
                    o_csr_wdata <= mstatus_next;
                end
                S_WR_MSTATUS: begin
                    state      <= S_RD_TGT;
                    o_csr_ren  <= 1'b1;
                    o_csr_addr <= is_mret ? CSR_MEPC : CSR_MTVEC;
                end
                S_RD_TGT: begin
                    state         <= S_REDIR;
                    o_redirect    <= 1'b1;
                    o_redirect_pc <= target;
                end
                S_REDIR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_210544_trap_ctrl.sv
module tb_ysyx_210544_trap_ctrl;

    localparam logic [63:0] A_MTIME    = 64'h0200_BFF8;
    localparam logic [63:0] A_MTIMECMP = 64'h0200_4000;
    localparam logic [63:0] INTR_CAUSE = 64'h8000_0000_0000_0007;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid, ecall, mret;
    logic [63:0] commit_pc, commit_npc;
    logic        csr_ren, csr_wen;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata, csr_rdata;
    logic        mmio_ren, mmio_wen;
    logic [63:0] mmio_addr, mmio_wdata, mmio_rdata;
    logic        mmio_hit, mtip, busy, redirect;
    logic [63:0] redirect_pc;

    // CSR file model
    logic [63:0] mepc, mcause, mstatus, mtvec;
    logic        mtie;
    logic        set_en;
    logic [11:0] set_addr;
    logic [63:0] set_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_210544_trap_ctrl #(
        .MTIME_DIV    (1),
        .MTIMECMP_RST (64'hFFFF_FFFF_FFFF_FFFF),
        .ADDR_MTIME   (A_MTIME),
        .ADDR_MTIMECMP(A_MTIMECMP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_commit_valid   (commit_valid),
        .i_commit_pc      (commit_pc),
        .i_commit_npc     (commit_npc),
        .i_ecall          (ecall),
        .i_mret           (mret),
        .i_csr_mstatus_mie(mstatus[3]),
        .i_csr_mie_mtie   (mtie),
        .o_csr_ren        (csr_ren),
        .o_csr_wen        (csr_wen),
        .o_csr_addr       (csr_addr),
        .o_csr_wdata      (csr_wdata),
        .i_csr_rdata      (csr_rdata),
        .i_mmio_ren       (mmio_ren),
        .i_mmio_wen       (mmio_wen),
        .i_mmio_addr      (mmio_addr),
        .i_mmio_wdata     (mmio_wdata),
        .o_mmio_rdata     (mmio_rdata),
        .o_mmio_hit       (mmio_hit),
        .o_mtip           (mtip),
        .o_busy           (busy),
        .o_redirect       (redirect),
        .o_redirect_pc    (redirect_pc)
    );

    always @(posedge clk) begin
        if (csr_wen || set_en) begin
            case (csr_wen ? csr_addr : set_addr)
                12'h341: mepc    <= csr_wen ? csr_wdata : set_data;
                12'h342: mcause  <= csr_wen ? csr_wdata : set_data;
                12'h300: mstatus <= csr_wen ? csr_wdata : set_data;
                12'h305: mtvec   <= csr_wen ? csr_wdata : set_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_ren) begin
            case (csr_addr)
                12'h341: csr_rdata = mepc;
                12'h342: csr_rdata = mcause;
                12'h300: csr_rdata = mstatus;
                12'h305: csr_rdata = mtvec;
                default: csr_rdata = '0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_set(input logic [11:0] a, input logic [63:0] d);
        set_en = 1'b1; set_addr = a; set_data = d;
        step();
        set_en = 1'b0;
    endtask

    task automatic mmio_write(input logic [63:0] a, input logic [63:0] d);
        mmio_wen = 1'b1; mmio_addr = a; mmio_wdata = d;
        step();
        mmio_wen = 1'b0; mmio_addr = '0; mmio_wdata = '0;
    endtask

    task automatic mmio_read(input string tag, input logic [63:0] a,
                             input logic [63:0] exp_data, input logic exp_hit);
        mmio_ren = 1'b1; mmio_addr = a;
        #1;
        check({tag, "_data"}, mmio_rdata, exp_data);
        check({tag, "_hit"}, {63'd0, mmio_hit}, {63'd0, exp_hit});
        mmio_ren = 1'b0; mmio_addr = '0;
    endtask

    task automatic commit(input logic [63:0] pc, input logic [63:0] npc,
                          input logic e, input logic m);
        commit_valid = 1'b1; commit_pc = pc; commit_npc = npc; ecall = e; mret = m;
        #1;
    endtask

    // Runs an accepted sequence: redirect expected exactly redir_k cycles
    // after accept, busy held until then, port never double-driven.
    task automatic run_seq(input string tag, input int redir_k, input logic [63:0] exp_pc);
        step();
        commit_valid = 1'b0; ecall = 1'b0; mret = 1'b0;
        for (int k = 1; k <= redir_k + 1; k++) begin
            check($sformatf("%s_redir_k%0d", tag, k), {63'd0, redirect}, {63'd0, k == redir_k});
            check($sformatf("%s_busy_k%0d", tag, k), {63'd0, busy}, {63'd0, k <= redir_k});
            check($sformatf("%s_excl_k%0d", tag, k), {63'd0, csr_ren & csr_wen}, 64'd0);
            if (k == redir_k)
                check({tag, "_pc"}, redirect_pc, exp_pc);
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        commit_valid = 1'b0; commit_pc = '0; commit_npc = '0; ecall = 1'b0; mret = 1'b0;
        mmio_ren = 1'b0; mmio_wen = 1'b0; mmio_addr = '0; mmio_wdata = '0;
        set_en = 1'b0; set_addr = '0; set_data = '0;
        mtie = 1'b0;
        mepc = '0; mcause = '0; mstatus = '0; mtvec = '0;
        step();
        step();

        // Reset state
        check("rst_ren", {63'd0, csr_ren}, 64'd0);
        check("rst_wen", {63'd0, csr_wen}, 64'd0);
        check("rst_mtip", {63'd0, mtip}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_redir", {63'd0, redirect}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_port", {62'd0, csr_ren, csr_wen}, 64'd0);
        end
        mmio_read("mtime10", A_MTIME, 64'd10, 1'b1);
        check("idle_mtip", {63'd0, mtip}, 64'd0);
        mmio_read("miss", 64'h0200_0000, 64'd0, 1'b0);
        mmio_read("cmp_rst", A_MTIMECMP, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        // ecall
        csr_set(12'h305, 64'h8000_0100);
        csr_set(12'h300, 64'h1808);
        commit(64'h8000_0010, 64'h8000_0014, 1'b1, 1'b0);
        check("ecall_accept_busy", {63'd0, busy}, 64'd1);
        run_seq("ecall", 6, 64'h8000_0100);
        check("ecall_mepc", mepc, 64'h8000_0010);
        check("ecall_mcause", mcause, 64'd11);
        check("ecall_mstatus", mstatus, 64'h1880);

        // mret
        csr_set(12'h341, 64'h8000_0014);
        commit(64'h8000_0200, 64'h8000_0204, 1'b0, 1'b1);
        check("mret_accept_busy", {63'd0, busy}, 64'd1);
        run_seq("mret", 4, 64'h8000_0014);
        check("mret_mstatus", mstatus, 64'h1888);

        // timer interrupt
        mtie = 1'b1;
        csr_set(12'h300, 64'h1800);
        mmio_write(A_MTIME, 64'd0);
        mmio_write(A_MTIMECMP, 64'd5);
        check("cmp_not_yet", {63'd0, mtip}, 64'd0);
        mmio_read("cmp_rd", A_MTIMECMP, 64'd5, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (mtip) break;
            step();
        end
        check("mtip_rise", {63'd0, mtip}, 64'd1);
        mmio_read("mtime_at_rise", A_MTIME, 64'd5, 1'b1);
        commit(64'h8000_001C, 64'h8000_0020, 1'b0, 1'b0);
        check("mie0_no_busy", {63'd0, busy}, 64'd0);
        step();
        commit_valid = 1'b0;
        check("mie0_no_port", {62'd0, csr_ren, csr_wen}, 64'd0);
        csr_set(12'h300, 64'h1808);
        commit(64'h8000_001C, 64'h8000_0020, 1'b0, 1'b0);
        check("intr_accept_busy", {63'd0, busy}, 64'd1);
        run_seq("intr", 6, 64'h8000_0100);
        check("intr_mepc", mepc, 64'h8000_0020);
        check("intr_mcause", mcause, INTR_CAUSE);
        check("intr_mstatus", mstatus, 64'h1880);

        // priority: mret + ecall + pending interrupt
        csr_set(12'h300, 64'h1888);
        csr_set(12'h341, 64'h8000_0014);
        commit(64'h8000_0300, 64'h8000_0304, 1'b1, 1'b1);
        run_seq("prio", 4, 64'h8000_0014);
        check("prio_mepc", mepc, 64'h8000_0014);
        check("prio_mcause", mcause, INTR_CAUSE);
        check("prio_mstatus", mstatus, 64'h1888);

        // mtime write overrides increment
        mmio_write(A_MTIME, 64'd100);
        mmio_read("mtime100", A_MTIME, 64'd100, 1'b1);

        // reset during WR_MSTATUS
        csr_set(12'h300, 64'h1808);
        commit(64'h8000_0400, 64'h8000_0404, 1'b1, 1'b0);
        step();
        commit_valid = 1'b0; ecall = 1'b0;
        step(); step(); step();
        check("midrst_in_wr_mstatus", {51'd0, csr_wen, csr_addr}, {51'd0, 1'b1, 12'h300});
        rst = 1'b1;
        step();
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_port", {62'd0, csr_ren, csr_wen}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("midrst_no_redir", {63'd0, redirect}, 64'd0);
            step();
        end

        // interrupt target with mtvec mode bits set
        csr_set(12'h305, 64'h8000_0101);
        mmio_write(A_MTIMECMP, 64'd0);
        check("vec_mtip", {63'd0, mtip}, 64'd1);
        csr_set(12'h300, 64'h1808);
        commit(64'h8000_003C, 64'h8000_0040, 1'b0, 1'b0);
        check("vec_accept_busy", {63'd0, busy}, 64'd1);
`ifdef YSYX_210544_MTVEC_VECTORED_EN
        run_seq("vec", 6, 64'h8000_011C);
`else
        run_seq("vec", 6, 64'h8000_0100);
`endif
        check("vec_mepc", mepc, 64'h8000_0040);
        check("vec_mcause", mcause, INTR_CAUSE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
